dma_port_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares the single DMA memory port between
//  N_REQ requesters (e.g. image loader, weight loader, result writer) of the DCNN IO path.

---
 rtl/dma_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dma_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_port_arbiter.sv
// rtl/dma_port_arbiter.sv - round-robin sequencer sharing one DMA memory port between requesters
module dma_port_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   dma_address,
    output logic [DATA_W-1:0]   dma_data,
    output logic                dma_read,
    output logic                dma_write,
    input  logic [DATA_W-1:0]   dma_dataout,
    input  logic                dma_done_read,
    input  logic                dma_done_write
);
    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W  = PTR_W + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(N_REQ - 1);

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [TCNT_W-1:0] tcnt;
    logic [PTR_W-1:0]  pick;
    logic              pick_valid;
    logic              op_done;

    // Round-robin selection: scan ptr, ptr+1, ... and keep the nearest set request
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx        = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(N_REQ)) begin
                idx = idx - IDX_W'(N_REQ);
            end
            if (req[idx[PTR_W-1:0]]) begin
                pick       = idx[PTR_W-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // Completion is ignored in the first ISSUE cycle so a done left over from the last op cannot end this one
    always_comb begin
        op_done = (tcnt != '0) &&
                  ((dma_read && dma_done_read) || (dma_write && dma_done_write));
    end

    // Sequencer: IDLE latches one request, ISSUE holds the strobe until done or timeout, ACK pulses for one cycle
    always_ff @(posedge clk) begin
        if (!RST) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            tcnt        <= '0;
            grant       <= '0;
            ack         <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            dma_address <= '0;
            dma_data    <= '0;
            dma_read    <= 1'b0;
            dma_write   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick;
                        grant       <= N_REQ'(1) << pick;
                        dma_address <= req_addr[pick*ADDR_W +: ADDR_W];
                        dma_data    <= req_wdata[pick*DATA_W +: DATA_W];
                        dma_write   <= req_we[pick];
                        dma_read    <= ~req_we[pick];
                        tcnt        <= '0;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tcnt <= tcnt + TCNT_W'(1);
                    if (op_done) begin
                        rdata     <= dma_read ? dma_dataout : '0;
                        err       <= 1'b0;
                        ack       <= grant;
                        dma_read  <= 1'b0;
                        dma_write <= 1'b0;
                        state     <= S_ACK;
                    end else if (tcnt == TCNT_LAST) begin
                        rdata     <= '0;
                        err       <= 1'b1;
                        ack       <= grant;
                        dma_read  <= 1'b0;
                        dma_write <= 1'b0;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack   <= '0;
                    grant <= '0;
                    err   <= 1'b0;
                    rdata <= '0;
                    busy  <= 1'b0;
                    ptr   <= (owner == PTR_MAX) ? '0 : owner + PTR_W'(1);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_port_arbiter.sv
// tb/tb_dma_port_arbiter.sv - self-checking bench for dma_port_arbiter with DMA memory model
module tb_dma_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            RST;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant, ack;
    logic            err, busy;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   dma_address;
    logic [DW-1:0]   dma_data;
    logic            dma_read, dma_write;
    logic [DW-1:0]   dma_dataout;
    logic            dma_done_read, dma_done_write;

    always #5 clk = ~clk;

    dma_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .RST(RST), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .grant(grant), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .dma_address(dma_address), .dma_data(dma_data),
        .dma_read(dma_read), .dma_write(dma_write), .dma_dataout(dma_dataout),
        .dma_done_read(dma_done_read), .dma_done_write(dma_done_write)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acks = 0;

    logic [DW-1:0] dma_mem [16];
    logic [DW-1:0] ref_mem [16];
    int dly      = 1;
    bit rand_dly = 0;
    int s_cnt    = 0;

    bit            m_busy = 0;
    int            m_ptr = 0, m_owner = 0, m_kdone = 0, m_start = 0, strobe_n = 0;
    bit            m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            hold [N];
    int            order [$];
    int            last_owner = -1, last_strobe = 0;
    bit            last_err;
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_data;
    logic          seen_wr, seen_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // first requester with req set, scanning from p around the ring
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    task automatic monitor();
        int o, kd;
        if (!m_busy) begin
            chk("idle_ack", ack, 0);
            if (grant != 0) begin
                o = rr_pick(req, m_ptr);
                chk("grant_owner", grant, (o < 0) ? 0 : (1 << o));
                if (o < 0) o = 0;
                m_owner = o;
                m_we    = req_we[o];
                m_addr  = req_addr[o*AW +: AW];
                m_data  = req_wdata[o*DW +: DW];
                seen_addr = dma_address; seen_data = dma_data;
                seen_wr   = dma_write;   seen_rd   = dma_read;
                chk("grant_wr", dma_write, m_we);
                chk("grant_rd", dma_read, !m_we);
                chk("grant_addr", dma_address, m_addr);
                chk("grant_data", dma_data, m_data);
                chk("grant_busy", busy, 1);
                if (rand_dly) dly = $urandom_range(0, 9);
                kd      = (dly < 1) ? 1 : dly;
                m_err   = (kd > TO - 1);
                m_kdone = m_err ? TO - 1 : kd;
                m_busy  = 1;
                strobe_n = 0;
                m_start = cyc;
                order.push_back(o);
            end
        end
        if (m_busy) begin
            if (dma_read || dma_write) strobe_n++;
            if (ack != 0) begin
                chk("ack_owner", ack, 1 << m_owner);
                chk("ack_grant", grant, 1 << m_owner);
                chk("ack_err", err, m_err);
                chk("ack_rdata", rdata, (m_err || m_we) ? 0 : ref_mem[m_addr[3:0]]);
                chk("ack_latency", cyc - m_start, m_kdone + 1);
                chk("strobe_cycles", strobe_n, m_kdone + 1);
                chk("ack_strobes_off", {dma_read, dma_write}, 0);
                chk("ack_addr_held", dma_address, m_addr);
                if (!m_err && m_we) ref_mem[m_addr[3:0]] = m_data;
                m_ptr       = (m_owner + 1) % N;
                last_owner  = m_owner;
                last_err    = err;
                last_rdata  = rdata;
                last_strobe = strobe_n;
                n_acks++;
                if (!hold[m_owner]) req[m_owner] = 1'b0;
                m_busy = 0;
            end else if (cyc - m_start > TO + 4) begin
                chk("ack_missing", 0, 1);
                m_busy = 0;
            end
        end
    endtask

    // one cycle: check at the falling edge, then let the DMA model respond to the strobes
    task automatic tick();
        bit done;
        @(negedge clk);
        cyc++;
        monitor();
        if (dma_read || dma_write) s_cnt++;
        else s_cnt = 0;
        done = (dma_read || dma_write) && (s_cnt - 1 >= dly);
        if (dma_write && done) dma_mem[dma_address[3:0]] = dma_data;
        dma_done_write = dma_write ? done : 1'($urandom);
        dma_done_read  = dma_read  ? done : 1'($urandom);
        dma_dataout    = dma_read ? dma_mem[dma_address[3:0]] : DW'($urandom);
    endtask

    task automatic post(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req[i]                 = 1'b1;
    endtask

    task automatic wait_acks(input int n);
        int target;
        target = n_acks + n;
        for (int t = 0; t < 20 * n && n_acks < target; t++) tick();
        chk("wait_acks", n_acks >= target, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int a0;
        RST = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        dma_dataout = '0; dma_done_read = 1'b0; dma_done_write = 1'b0;
        for (int i = 0; i < 16; i++) begin dma_mem[i] = '0; ref_mem[i] = '0; end
        for (int i = 0; i < N; i++) hold[i] = 0;

        // reset with random requests
        for (int i = 0; i < 3; i++) begin req = N'($urandom); tick(); end
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_wr", {dma_read, dma_write}, 0);
        chk("rst_rdata", rdata, 0);
        req = '0;
        RST = 1'b1;
        tick();

        // single write, done two cycles after the strobe
        dly = 2;
        a0 = n_acks;
        post(0, 1, 16'h0000, 16'hF001);
        wait_acks(1);
        chk("t2_wr", seen_wr, 1);
        chk("t2_addr", seen_addr, 16'h0000);
        chk("t2_data", seen_data, 16'hF001);
        chk("t2_owner", last_owner, 0);
        chk("t2_err", last_err, 0);
        tick();
        chk("t2_ack_pulse", ack, 0);
        chk("t2_one_ack", n_acks - a0, 1);

        // write then read back the same address
        post(0, 1, 16'h0001, 16'hF0F0);
        wait_acks(1);
        tick();
        post(1, 0, 16'h0001, 16'h1234);
        wait_acks(1);
        chk("t3_rd", seen_rd, 1);
        chk("t3_owner", last_owner, 1);
        chk("t3_rdata", last_rdata, 16'hF0F0);
        chk("t3_err", last_err, 0);
        tick();

        // timeout: no done ever
        dly = 100;
        post(2, 0, 16'h0003, 16'h0);
        wait_acks(1);
        chk("t5_err", last_err, 1);
        chk("t5_rdata", last_rdata, 0);
        chk("t5_strobe", last_strobe, TO);
        tick();
        dly = 1;

        // all three held: rotation 0,1,2,0,1,2
        order.delete();
        for (int i = 0; i < N; i++) begin hold[i] = 1; post(i, i[0], AW'(4 + i), DW'(16'hA000 + i)); end
        wait_acks(3);
        for (int i = 0; i < N; i++) hold[i] = 0;
        wait_acks(3);
        chk("t4_len", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) chk("t4_order", order[i], i % 3);
        tick();

        // only 0 and 2 held: alternates 0,2,0,2
        order.delete();
        hold[0] = 1; hold[2] = 1;
        post(0, 0, 16'h0004, 16'h0);
        post(2, 1, 16'h0006, 16'hBEEF);
        wait_acks(2);
        hold[0] = 0; hold[2] = 0;
        wait_acks(2);
        chk("t4b_len", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("t4b_order", order[i], (i % 2) * 2);
        tick();

        // move the pointer to 2, then reset in the 2nd ISSUE cycle of a read from requester 2
        post(1, 1, 16'h0007, 16'h7777);
        wait_acks(1);
        tick();
        dly = 100;
        post(2, 0, 16'h0005, 16'h0);
        for (int t = 0; t < 20 && !m_busy; t++) tick();
        chk("t6_granted", m_busy, 1);
        tick();
        RST = 1'b0;
        tick();
        chk("t6_strobes", {dma_read, dma_write}, 0);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ack", ack, 0);
        m_busy = 0; m_ptr = 0; req = '0;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dly = 1;
        post(1, 0, 16'h0001, 16'h0);
        post(2, 0, 16'h0002, 16'h0);
        wait_acks(1);
        chk("t6_prio", last_owner, 1);
        wait_acks(1);
        chk("t6_next", last_owner, 2);

        // randomized traffic
        rand_dly = 1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0)
                    post(i, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            end
            if (m_busy && $urandom_range(0, 3) == 0) begin
                req_addr[m_owner*AW +: AW]  = AW'($urandom_range(0, 15));
                req_wdata[m_owner*DW +: DW] = DW'($urandom);
                req_we[m_owner]             = 1'($urandom);
            end
        end
        for (int t = 0; t < 200 && (req != 0 || m_busy); t++) tick();
        chk("drain", {req != 0, m_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
